// File: rtl/word_select_controller.sv
`timescale 1ns/1ps
// word_select_controller: drives the LFSR RNG to choose a secret word index that
// has not yet been played in this session, then fetches that word from the ROM.
// A used-index bitmap prevents repeats. After MAX_RETRY rejected RNG draws, a
// linear probe takes over. The probe always finds a free index because a full
// bitmap is cleared before a new pick starts.
module word_select_controller #(
  parameter int unsigned NUM_WORDS   = 100,
  parameter int unsigned WORD_W      = 40,
  parameter int unsigned ROM_LATENCY = 1,
  parameter int unsigned MAX_RETRY   = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_new_game,
  input  logic              i_word_ack,
  input  logic              i_clear_history,
  output logic              o_rng_step,
  input  logic [6:0]        i_rng_value,
  output logic [6:0]        o_rom_addr,
  input  logic [WORD_W-1:0] i_rom_data,
  output logic [WORD_W-1:0] o_word,
  output logic [6:0]        o_word_index,
  output logic              o_word_valid,
  output logic              o_busy,
  output logic              o_exhausted,
  output logic [6:0]        o_used_count
);

  localparam int unsigned IDX_W   = 7;
  localparam int unsigned MAP_W   = 1 << IDX_W;
  localparam int unsigned RETRY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  localparam int unsigned FETCH_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STEP   = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_PROBE  = 3'd4,
    S_FETCH  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t             r_state;
  logic [MAP_W-1:0]   r_used;
  logic [IDX_W-1:0]   r_used_count;
  logic [RETRY_W-1:0] r_retry;
  logic [FETCH_W-1:0] r_fetch_cnt;
  logic [IDX_W-1:0]   r_probe;
  logic [IDX_W-1:0]   r_rom_addr;
  logic [WORD_W-1:0]  r_word;
  logic [IDX_W-1:0]   r_word_index;
  logic               r_word_valid;
  logic               r_rng_step;
  logic               r_busy;
  logic               r_exhausted;

  logic [IDX_W-1:0]   w_idx;
  logic               w_idx_ok;
  logic               w_check_accept;
  logic               w_probe_accept;
  logic [IDX_W-1:0]   w_probe_start;
  logic [IDX_W-1:0]   w_probe_next;

  // Candidate index from the RNG, and the linear-probe start and advance indices.
  always_comb begin
    w_idx          = i_rng_value - IDX_W'(1);
    w_idx_ok       = (w_idx < IDX_W'(NUM_WORDS));
    w_check_accept = w_idx_ok && !r_used[w_idx];
    w_probe_accept = !r_used[r_probe];
    w_probe_start  = '0;
    if (w_idx_ok && (w_idx != IDX_W'(NUM_WORDS - 1))) begin
      w_probe_start = w_idx + IDX_W'(1);
    end
    w_probe_next = '0;
    if (r_probe != IDX_W'(NUM_WORDS - 1)) begin
      w_probe_next = r_probe + IDX_W'(1);
    end
  end

  // Selection FSM, bitmap bookkeeping and all registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_used       <= '0;
      r_used_count <= '0;
      r_retry      <= '0;
      r_fetch_cnt  <= '0;
      r_probe      <= '0;
      r_rom_addr   <= '0;
      r_word       <= '0;
      r_word_index <= '0;
      r_word_valid <= 1'b0;
      r_rng_step   <= 1'b0;
      r_busy       <= 1'b0;
      r_exhausted  <= 1'b0;
    end else begin
      r_rng_step  <= 1'b0;
      r_exhausted <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_clear_history) begin
            r_used       <= '0;
            r_used_count <= '0;
          end else if (i_new_game) begin
            r_state    <= S_STEP;
            r_retry    <= '0;
            r_rng_step <= 1'b1;
            r_busy     <= 1'b1;
            // Every word has been played: start a fresh session.
            if (r_used_count == IDX_W'(NUM_WORDS)) begin
              r_used       <= '0;
              r_used_count <= '0;
              r_exhausted  <= 1'b1;
            end
          end
        end
        S_STEP: begin
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (w_check_accept) begin
            r_used[w_idx] <= 1'b1;
            r_used_count  <= r_used_count + IDX_W'(1);
            r_rom_addr    <= w_idx;
            r_fetch_cnt   <= '0;
            r_state       <= S_FETCH;
          end else if (r_retry < RETRY_W'(MAX_RETRY - 1)) begin
            r_retry    <= r_retry + RETRY_W'(1);
            r_rng_step <= 1'b1;
            r_state    <= S_STEP;
          end else begin
            r_probe <= w_probe_start;
            r_state <= S_PROBE;
          end
        end
        S_PROBE: begin
          if (w_probe_accept) begin
            r_used[r_probe] <= 1'b1;
            r_used_count    <= r_used_count + IDX_W'(1);
            r_rom_addr      <= r_probe;
            r_fetch_cnt     <= '0;
            r_state         <= S_FETCH;
          end else begin
            r_probe <= w_probe_next;
          end
        end
        S_FETCH: begin
          if (r_fetch_cnt == FETCH_W'(ROM_LATENCY - 1)) begin
            r_word       <= i_rom_data;
            r_word_index <= r_rom_addr;
            r_word_valid <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_fetch_cnt <= r_fetch_cnt + FETCH_W'(1);
          end
        end
        S_DONE: begin
          if (i_word_ack) begin
            r_word_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_rng_step   = r_rng_step;
  assign o_rom_addr   = r_rom_addr;
  assign o_word       = r_word;
  assign o_word_index = r_word_index;
  assign o_word_valid = r_word_valid;
  assign o_busy       = r_busy;
  assign o_exhausted  = r_exhausted;
  assign o_used_count = r_used_count;

endmodule

// File: tb/tb_word_select_controller.sv
`timescale 1ns/1ps
// Scoreboard bench for word_select_controller: RNG model fed from a queue,
// combinational ROM model, and expected picks queued per game.
module tb_word_select_controller;

  localparam int unsigned WORD_W = 40;

  typedef struct {
    int idx;
    int used;
  } exp_t;

  logic              clk;
  logic              reset_n;
  logic              new_game;
  logic              word_ack;
  logic              clear_history;
  logic              rng_step;
  logic [6:0]        rng_value;
  logic [6:0]        rom_addr;
  logic [WORD_W-1:0] rom_data;
  logic [WORD_W-1:0] word;
  logic [6:0]        word_index;
  logic              word_valid;
  logic              busy;
  logic              exhausted;
  logic [6:0]        used_count;

  int   n_checks;
  int   n_err;
  int   steps_total;
  int   exh_total;
  int   rng_q[$];
  exp_t sb_q[$];
  logic prev_step;
  logic prev_valid;

  word_select_controller #(
    .NUM_WORDS(100), .WORD_W(WORD_W), .ROM_LATENCY(1), .MAX_RETRY(4)
  ) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_new_game(new_game),
    .i_word_ack(word_ack), .i_clear_history(clear_history),
    .o_rng_step(rng_step), .i_rng_value(rng_value), .o_rom_addr(rom_addr),
    .i_rom_data(rom_data), .o_word(word), .o_word_index(word_index),
    .o_word_valid(word_valid), .o_busy(busy), .o_exhausted(exhausted),
    .o_used_count(used_count)
  );

  function automatic logic [WORD_W-1:0] rom_fn(input logic [6:0] a);
    logic [25:0] lo;
    lo = 26'(a * 3 + 17);
    return {a, a ^ 7'h55, lo};
  endfunction

  assign rom_data = rom_fn(rom_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // RNG model: each step pulse advances to the next queued value.
  always @(negedge clk) begin
    if (rng_step) begin
      steps_total++;
      check("rng_pulse_width", 64'(prev_step), 64'd0);
      if (rng_q.size() > 0) rng_value = 7'(rng_q.pop_front());
      else rng_value = 7'd0;
    end
    prev_step = rng_step;
    if (exhausted) exh_total++;
  end

  // Scoreboard: compare each newly presented word against the queued expectation.
  always @(negedge clk) begin
    if (word_valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_word", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("word_index", 64'(word_index), 64'(e.idx));
        check("word_data", 64'(word), 64'(rom_fn(7'(e.idx))));
        check("used_count", 64'(used_count), 64'(e.used));
      end
    end
    prev_valid = word_valid;
  end

  task automatic run_game(input string tag, input int exp_idx, input int exp_steps,
                          input int exp_lat, input int exp_used,
                          input bit hold_clear, input bit poke_done,
                          output bit exh_s, output int uc_s);
    int lat;
    int s0;
    exp_t e;
    e.idx  = exp_idx;
    e.used = exp_used;
    sb_q.push_back(e);
    s0 = steps_total;
    @(negedge clk); new_game = 1'b1;
    @(posedge clk); #1; new_game = 1'b0;
    exh_s = exhausted;
    uc_s  = int'(used_count);
    if (hold_clear) clear_history = 1'b1;
    lat = 0;
    while (!word_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    clear_history = 1'b0;
    check({tag, "_valid"}, 64'(word_valid), 64'd1);
    if (exp_lat >= 0) check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_steps"}, 64'(steps_total - s0), 64'(exp_steps));
    if (poke_done) begin
      s0 = steps_total;
      @(negedge clk); new_game = 1'b1;
      @(posedge clk); #1; new_game = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_done_hold"}, 64'(word_valid), 64'd1);
      check({tag, "_done_nostep"}, 64'(steps_total - s0), 64'd0);
    end
    @(negedge clk); word_ack = 1'b1;
    @(posedge clk); #1; word_ack = 1'b0;
    check({tag, "_ack_valid"}, 64'(word_valid), 64'd0);
    check({tag, "_ack_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    bit exh_s;
    int uc_s;
    int s0;
    int e0;
    n_checks = 0; n_err = 0; steps_total = 0; exh_total = 0;
    prev_step = 1'b0; prev_valid = 1'b0;
    reset_n = 1'b0; new_game = 1'b0; word_ack = 1'b0; clear_history = 1'b0;
    rng_value = 7'd1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(word_valid), 64'd0);
    check("rst_step", 64'(rng_step), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_used", 64'(used_count), 64'd0);
    check("rst_exh", 64'(exhausted), 64'd0);
    check("rst_addr", 64'(rom_addr), 64'd0);
    check("rst_word", 64'(word), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    repeat (5) @(posedge clk);

    // Basic pick: rng 37 -> index 36.
    rng_q.push_back(37);
    run_game("basic", 36, 1, 4, 1, 1'b0, 1'b0, exh_s, uc_s);
    check("basic_rom_addr", 64'(rom_addr), 64'd36);

    // Repeat rejection: 37 (used) then 52.
    rng_q.push_back(37); rng_q.push_back(52);
    run_game("repeat", 51, 2, 7, 2, 1'b0, 1'b0, exh_s, uc_s);

    // Mark 37 used, then four rejected draws fall into the probe.
    rng_q.push_back(38);
    run_game("prep", 37, 1, 4, 3, 1'b0, 1'b0, exh_s, uc_s);
    repeat (4) rng_q.push_back(37);
    run_game("probe", 38, 4, 15, 4, 1'b0, 1'b0, exh_s, uc_s);

    // Out-of-range draws: probe starts at index 0.
    rng_q.push_back(120); rng_q.push_back(0); rng_q.push_back(101); rng_q.push_back(127);
    run_game("oor", 0, 4, 14, 5, 1'b0, 1'b0, exh_s, uc_s);

    // clear_history outside IDLE is ignored; new_game in DONE is ignored.
    rng_q.push_back(11);
    run_game("clr_busy", 10, 1, 4, 6, 1'b1, 1'b1, exh_s, uc_s);
    rng_q.push_back(11); rng_q.push_back(12);
    run_game("kept", 11, 2, 7, 7, 1'b0, 1'b0, exh_s, uc_s);

    // Reset asserted while fetching.
    rng_q.push_back(21);
    @(negedge clk); new_game = 1'b1;
    @(posedge clk); #1; new_game = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_addr", 64'(rom_addr), 64'd20);
    #1; reset_n = 1'b0;
    #1;
    check("midrst_valid", 64'(word_valid), 64'd0);
    check("midrst_used", 64'(used_count), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_step", 64'(rng_step), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(posedge clk);
    rng_q.push_back(37);
    run_game("after_rst", 36, 1, 4, 1, 1'b0, 1'b0, exh_s, uc_s);

    // clear_history beats new_game in IDLE.
    s0 = steps_total;
    @(negedge clk); clear_history = 1'b1; new_game = 1'b1;
    @(posedge clk); #1; clear_history = 1'b0; new_game = 1'b0;
    check("clr_used", 64'(used_count), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("clr_busy_idle", 64'(busy), 64'd0);
    check("clr_nostep", 64'(steps_total - s0), 64'd0);

    // Exhaustion: fill all 100 indices, then one more game.
    e0 = exh_total;
    for (int i = 1; i <= 100; i++) begin
      rng_q.push_back(i);
      run_game("fill", i - 1, 1, 4, i, 1'b0, 1'b0, exh_s, uc_s);
    end
    check("fill_noexh", 64'(exh_total - e0), 64'd0);
    check("full_count", 64'(used_count), 64'd100);
    rng_q.push_back(50);
    run_game("exhaust", 49, 1, 4, 1, 1'b0, 1'b0, exh_s, uc_s);
    check("exh_pulse_at_step", 64'(exh_s), 64'd1);
    check("exh_used_at_step", 64'(uc_s), 64'd0);
    check("exh_once", 64'(exh_total - e0), 64'd1);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
